// File: rtl/pio_mbox_pkg.sv
// Shared types for the HPS<->FPGA PIO mailbox responder.
// Build option: PIO_MBOX_STATS_EN enables command/error statistics (op 6).
package pio_mbox_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WR_LO = 3'd1,
    OP_WR_HI = 3'd2,
    OP_RD_LO = 3'd3,
    OP_RD_HI = 3'd4,
    OP_INC   = 3'd5,
    OP_STATS = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RF_NONE,
    RF_WR_LO,
    RF_WR_HI,
    RF_INC
  } rf_op_e;

  // Command word: [31] tgl, [30:28] op, [27:24] addr, [23:16] ignored, [15:0] data
  typedef struct packed {
    logic        tgl;
    op_e         op;
    logic [3:0]  addr;
    logic [7:0]  rsvd;
    logic [15:0] data;
  } cmd_t;

  // Response word: [31] ack, [30] busy, [29] err, [28:26] op, [25:22] addr, [15:0] rdata
  typedef struct packed {
    logic        ack;
    logic        busy;
    logic        err;
    op_e         op;
    logic [3:0]  addr;
    logic [5:0]  zero;
    logic [15:0] rdata;
  } rsp_t;

  localparam logic [3:0] USER_IN_ADDR = 4'd15;

endpackage

// File: rtl/pio_mbox_regfile.sv
// NREGS x 32-bit register file: one port with lo/hi half-writes and increment,
// plus a register-0 tap.
module pio_mbox_regfile
  import pio_mbox_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  rf_op_e      op,
  input  logic [3:0]  addr,
  input  logic [15:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] reg0
);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (addr == 4'(i)) begin
          case (op)
            RF_WR_LO: regs[i][15:0]  <= wdata;
            RF_WR_HI: regs[i][31:16] <= wdata;
            RF_INC:   regs[i]        <= regs[i] + 32'd1;
            default:  ;
          endcase
        end
      end
    end
  end

  // Out-of-range addresses read as zero; the caller flags them as errors.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (addr == 4'(i)) rdata = regs[i];
    end
  end

  assign reg0 = regs[0];

endmodule

// File: rtl/pio_mbox_responder.sv
// FPGA-side responder for the HPS<->FPGA toggle-handshake PIO mailbox.
// Build option: PIO_MBOX_STATS_EN adds cmd/err counters readable via op 6.
module pio_mbox_responder
  import pio_mbox_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [31:0] pp_out_axi,
  output logic [31:0] pp_in_axi,
  input  logic [31:0] user_in,
  output logic [31:0] user_out
);

  state_e      state, state_nxt;
  cmd_t        in_q, cmd_q;
  rsp_t        rsp_q;
  logic [31:0] snap_q;
  logic        ack_tgl;
  logic        err_q;
  logic [15:0] rdata_q;

  logic        do_cap, do_exec, do_resp;
  logic        err;
  logic [15:0] rdata_nxt;
  rf_op_e      rf_dec, rf_op;
  logic [31:0] rf_rdata;
  logic        addr_ok, is_user;

  logic unused_rsvd;
  assign unused_rsvd = ^{cmd_q.rsvd, in_q.rsvd};

`ifdef PIO_MBOX_STATS_EN
  logic [15:0] cmd_cnt, err_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      cmd_cnt <= '0;
      err_cnt <= '0;
    end else if (do_exec) begin
      cmd_cnt <= cmd_cnt + 16'd1;
      if (err) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_cap    = 1'b0;
    do_exec   = 1'b0;
    do_resp   = 1'b0;
    case (state)
      ST_IDLE:   if (in_q.tgl != ack_tgl) state_nxt = ST_SETTLE;
      ST_SETTLE: begin do_cap  = 1'b1; state_nxt = ST_EXEC; end
      ST_EXEC:   begin do_exec = 1'b1; state_nxt = ST_RESP; end
      ST_RESP:   begin do_resp = 1'b1; state_nxt = ST_IDLE; end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign addr_ok = 32'(cmd_q.addr) < NREGS;
  assign is_user = cmd_q.addr == USER_IN_ADDR;

  always_comb begin
    err       = 1'b0;
    rf_dec    = RF_NONE;
    rdata_nxt = '0;
    case (cmd_q.op)
      OP_NOP:   rdata_nxt = cmd_q.data;
      OP_WR_LO: begin rf_dec = RF_WR_LO; rdata_nxt = cmd_q.data; end
      OP_WR_HI: begin rf_dec = RF_WR_HI; rdata_nxt = cmd_q.data; end
      OP_RD_LO: rdata_nxt = is_user ? snap_q[15:0]  : rf_rdata[15:0];
      OP_RD_HI: rdata_nxt = is_user ? snap_q[31:16] : rf_rdata[31:16];
      OP_INC:   begin rf_dec = RF_INC; rdata_nxt = rf_rdata[15:0] + 16'd1; end
`ifdef PIO_MBOX_STATS_EN
      OP_STATS: rdata_nxt = cmd_q.data[0] ? err_cnt : cmd_cnt;
`endif
      default:  err = 1'b1;
    endcase
    if (!addr_ok && !is_user)        err = 1'b1;
    if (is_user && rf_dec != RF_NONE) err = 1'b1;
    if (err) begin
      rdata_nxt = '0;
      rf_dec    = RF_NONE;
    end
  end

  assign rf_op = do_exec ? rf_dec : RF_NONE;

  pio_mbox_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .op    (rf_op),
    .addr  (cmd_q.addr),
    .wdata (cmd_q.data),
    .rdata (rf_rdata),
    .reg0  (user_out)
  );

  // Ack and payload are written in one edge so the HPS never pairs a new ack with stale data.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      in_q    <= '0;
      cmd_q   <= '0;
      snap_q  <= '0;
      rsp_q   <= '0;
      ack_tgl <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      in_q <= cmd_t'(pp_out_axi);
      if (do_cap) begin
        cmd_q      <= in_q;
        snap_q     <= user_in;
        rsp_q.busy <= 1'b1;
      end
      if (do_exec) begin
        err_q   <= err;
        rdata_q <= rdata_nxt;
      end
      if (do_resp) begin
        rsp_q   <= '{ack: cmd_q.tgl, busy: 1'b0, err: err_q, op: cmd_q.op,
                     addr: cmd_q.addr, zero: '0, rdata: rdata_q};
        ack_tgl <= cmd_q.tgl;
      end
    end
  end

  assign pp_in_axi = rsp_q;

endmodule

// File: tb/tb_pio_mbox_responder.sv
// Scoreboard bench for pio_mbox_responder; honours PIO_MBOX_STATS_EN.
module tb_pio_mbox_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pp_out_axi, pp_in_axi, user_in, user_out;

  typedef struct {
    logic [31:0] rsp;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int unsigned n_pass = 0, n_total = 0;
  logic        t;
  logic        prev_ack = 1'b0;

  pio_mbox_responder #(.NREGS(8)) dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .pp_out_axi (pp_out_axi),
    .pp_in_axi  (pp_in_axi),
    .user_in    (user_in),
    .user_out   (user_out)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Monitor: a new ack value means a response is presented.
  always @(negedge clk) begin
    if (!reset_n) prev_ack = 1'b0;
    else if (pp_in_axi[31] !== prev_ack) begin
      prev_ack = pp_in_axi[31];
      if (sb.size() == 0) chk("unexpected_rsp", pp_in_axi, 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        chk("rsp", pp_in_axi, e.rsp);
        chk("latency", cyc - e.cyc, 32'd5);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] data,
                      input logic exp_err, input logic [15:0] exp_rd);
    exp_t x;
    t = ~t;
    @(posedge clk); #1;
    pp_out_axi = {t, op, addr, 8'h00, data};
    x.rsp = {t, 1'b0, exp_err, op, addr, 6'b0, exp_rd};
    x.cyc = cyc;
    sb.push_back(x);
    for (int i = 1; i <= 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (i == 3) chk("busy_pre", 32'(pp_in_axi[30]), 32'd0);
      if (i == 4 || i == 5) chk("busy", 32'(pp_in_axi[30]), 32'd1);
    end
    #1;
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    pp_out_axi = '0;
    user_in    = '0;
    t          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pp_in", pp_in_axi, 32'h0000_0000);
    chk("rst_user_out", user_out, 32'h0);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_pp_in", pp_in_axi, 32'h0000_0000);
    chk("idle_user_out", user_out, 32'h0);

    send(3'd1, 4'd0, 16'h1234, 1'b0, 16'h1234);
    chk("ack_word_1", pp_in_axi, 32'h8400_1234);
    chk("user_out_lo", user_out, 32'h0000_1234);
    send(3'd2, 4'd0, 16'hABCD, 1'b0, 16'hABCD);
    chk("ack_word_2", pp_in_axi, 32'h0800_ABCD);
    chk("user_out_full", user_out, 32'hABCD_1234);

    send(3'd1, 4'd3, 16'hFFFF, 1'b0, 16'hFFFF);
    send(3'd2, 4'd3, 16'hFFFF, 1'b0, 16'hFFFF);
    send(3'd5, 4'd3, 16'h0000, 1'b0, 16'h0000);
    send(3'd4, 4'd3, 16'h0000, 1'b0, 16'h0000);
    send(3'd3, 4'd3, 16'h0000, 1'b0, 16'h0000);
    send(3'd5, 4'd3, 16'h0000, 1'b0, 16'h0001);

    user_in = 32'hCAFE_F00D;
    send(3'd4, 4'd15, 16'h0000, 1'b0, 16'hCAFE);
    send(3'd3, 4'd15, 16'h0000, 1'b0, 16'hF00D);
    send(3'd1, 4'd15, 16'h1111, 1'b1, 16'h0000);
    send(3'd5, 4'd15, 16'h0000, 1'b1, 16'h0000);
    send(3'd0, 4'd8,  16'h0055, 1'b1, 16'h0000);
    send(3'd7, 4'd0,  16'h0000, 1'b1, 16'h0000);
    send(3'd0, 4'd1,  16'h00A5, 1'b0, 16'h00A5);
    chk("user_out_kept", user_out, 32'hABCD_1234);

    // Reset lands while the WR_LO is in EXEC; the write must not happen.
    t = ~t;
    @(posedge clk); #1;
    pp_out_axi = {t, 3'd1, 4'd0, 8'h00, 16'h7777};
    repeat (3) @(posedge clk);
    #1;
    reset_n    = 1'b0;
    pp_out_axi = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pp_in", pp_in_axi, 32'h0);
    chk("abort_user_out", user_out, 32'h0);
    reset_n = 1'b1;
    t       = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle_pp_in", pp_in_axi, 32'h0);

    send(3'd3, 4'd0, 16'h0000, 1'b0, 16'h0000);
    send(3'd1, 4'd1, 16'h0042, 1'b0, 16'h0042);
    send(3'd0, 4'd2, 16'h0007, 1'b0, 16'h0007);
    send(3'd7, 4'd0, 16'h0000, 1'b1, 16'h0000);
`ifdef PIO_MBOX_STATS_EN
    send(3'd6, 4'd0, 16'h0000, 1'b0, 16'h0004);
    send(3'd6, 4'd0, 16'h0001, 1'b0, 16'h0001);
`else
    send(3'd6, 4'd0, 16'h0000, 1'b1, 16'h0000);
    send(3'd6, 4'd0, 16'h0001, 1'b1, 16'h0000);
`endif
    send(3'd4, 4'd0, 16'h0000, 1'b0, 16'h0000);
    chk("final_user_out", user_out, 32'h0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
